// File: rtl/modem_symbol_detector.sv
// Recovers one data bit per SPS-sample symbol from the modulator's 7-bit offset-binary stream.
// Demodulates ASK by envelope energy, FSK by zero-crossing count, DPSK by sign agreement with the previous symbol.
module modem_symbol_detector #(
    parameter int SPS           = 16,
    parameter int MID           = 64,
    parameter int ASK_THRESH    = 256,
    parameter int FSK_ZC_THRESH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic [6:0] sample_in,
    input  logic       sample_valid,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] sym_cnt
);

    localparam int IW = $clog2(SPS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;

    localparam logic [1:0] MODE_ASK  = 2'b00;
    localparam logic [1:0] MODE_FSK  = 2'b01;
    localparam logic [1:0] MODE_DPSK = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    localparam logic [IW-1:0] IDX_LAST = IW'(SPS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [1:0]     state;
    logic [1:0]     sel_q;
    logic [IW-1:0]  idx;
    logic [12:0]    ask_acc;
    logic [6:0]     zc;
    logic [6:0]     agree;
    logic [SPS-1:0] hist;
    logic           prev_sign;
    logic           primed;

    logic [7:0]     samp_ext;
    logic [7:0]     mid_ext;
    logic           sgn;
    logic [7:0]     dev;
    logic [12:0]    ask_next;
    logic           crossing;
    logic [6:0]     zc_next;
    logic [6:0]     agree_next;
    logic [SPS-1:0] hist_next;
    logic           decision;
    logic           abort;
    logic           accept;
    logic           last;

    always_comb begin
        samp_ext   = {1'b0, sample_in};
        mid_ext    = 8'(MID);
        sgn        = (samp_ext >= mid_ext);
        dev        = sgn ? (samp_ext - mid_ext) : (mid_ext - samp_ext);
        ask_next   = ask_acc + {5'b0, dev};
        // The first sample after IDLE only seeds prev_sign; it is never a crossing.
        crossing   = (state != ST_IDLE) && (sgn != prev_sign);
        zc_next    = zc + {6'b0, crossing};
        agree_next = agree + {6'b0, (sgn == hist[SPS-1])};
        hist_next  = {hist[SPS-2:0], sgn};
        abort      = (sel != sel_q) || (sel == MODE_OFF);
        accept     = sample_valid && !abort;
        last       = (idx == IDX_LAST);
        decision   = 1'b0;
        case (sel)
            MODE_ASK:  decision = (ask_next >= 13'(ASK_THRESH));
            MODE_FSK:  decision = (zc_next >= 7'(FSK_ZC_THRESH));
            MODE_DPSK: decision = (agree_next >= 7'(SPS / 2));
            default:   decision = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel_q     <= 2'b00;
            idx       <= '0;
            ask_acc   <= '0;
            zc        <= '0;
            agree     <= '0;
            hist      <= '0;
            prev_sign <= 1'b0;
            primed    <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            sym_cnt   <= '0;
        end else begin
            sel_q     <= sel;
            bit_valid <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                idx     <= '0;
                ask_acc <= '0;
                zc      <= '0;
                agree   <= '0;
                hist    <= '0;
                primed  <= 1'b0;
            end else if (accept) begin
                prev_sign <= sgn;
                hist      <= hist_next;
                if (last) begin
                    // Decision is registered on the accepting edge so bit_valid is visible during DECIDE.
                    state   <= ST_DECIDE;
                    idx     <= '0;
                    ask_acc <= '0;
                    zc      <= '0;
                    agree   <= '0;
                    primed  <= 1'b1;
                    if (sel != MODE_DPSK || primed) begin
                        bit_out   <= decision;
                        bit_valid <= 1'b1;
                        sym_cnt   <= sym_cnt + 8'd1;
                    end
                end else begin
                    state   <= ST_ACCUM;
                    idx     <= idx + IDX_ONE;
                    ask_acc <= ask_next;
                    zc      <= zc_next;
                    agree   <= agree_next;
                end
            end else if (state == ST_DECIDE) begin
                state <= ST_ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_modem_symbol_detector.sv
// Directed-vector bench for modem_symbol_detector (SPS=16, MID=64, ASK_THRESH=256, FSK_ZC_THRESH=4).
module tb_modem_symbol_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic [6:0] sample_in;
    logic       sample_valid;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] sym_cnt;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int p0;

    modem_symbol_detector #(
        .SPS(16),
        .MID(64),
        .ASK_THRESH(256),
        .FSK_ZC_THRESH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sel(sel),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bit_valid === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] v);
        @(negedge clk);
        sample_in    = v;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] s);
        @(negedge clk);
        sel          = s;
        sample_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        reset        = 1'b1;
        sel          = 2'b00;
        sample_in    = 7'd64;
        sample_valid = 1'b0;
        #12;
        check("reset_bit_out", bit_out, 0);
        check("reset_bit_valid", bit_valid, 0);
        check("reset_sym_cnt", sym_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // ASK: 16 x 127 -> acc=1008 -> 1; 16 x 64 -> acc=0 -> 0
        for (int i = 0; i < 15; i++) send(7'd127);
        check("ask_no_early_valid", bit_valid, 0);
        send(7'd127);
        check("ask1_valid", bit_valid, 1);
        check("ask1_bit", bit_out, 1);
        check("ask1_cnt", sym_cnt, 1);
        send(7'd64);
        check("ask_valid_one_cycle", bit_valid, 0);
        for (int i = 1; i < 16; i++) send(7'd64);
        check("ask2_valid", bit_valid, 1);
        check("ask2_bit", bit_out, 0);
        check("ask2_cnt", sym_cnt, 2);
        idle(2);
        check("ask_pulse_count", pulses, 2);

        // FSK: period-4 square (7 then 8 crossings) -> 1,1; period-16 starting low (1 crossing) -> 0
        do_reset(2'b01);
        p0 = pulses;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) send((((i / 2) % 2) == 0) ? 7'd100 : 7'd28);
            check("fsk_fast_valid", bit_valid, 1);
            check("fsk_fast_bit", bit_out, 1);
            check("fsk_fast_cnt", sym_cnt, s + 1);
        end
        for (int i = 0; i < 16; i++) send((i < 8) ? 7'd28 : 7'd100);
        check("fsk_slow_valid", bit_valid, 1);
        check("fsk_slow_bit", bit_out, 0);
        check("fsk_slow_cnt", sym_cnt, 3);
        idle(2);
        check("fsk_pulse_count", pulses - p0, 3);

        // DPSK: sign pattern 1100; symbol 1 primes only, symbol 2 agree=16 -> 1, symbol 3 inverted -> 0
        do_reset(2'b10);
        p0 = pulses;
        for (int i = 0; i < 16; i++) send(((i % 4) < 2) ? 7'd100 : 7'd28);
        check("dpsk_prime_no_valid", bit_valid, 0);
        check("dpsk_prime_cnt", sym_cnt, 0);
        for (int i = 0; i < 16; i++) send(((i % 4) < 2) ? 7'd100 : 7'd28);
        check("dpsk2_valid", bit_valid, 1);
        check("dpsk2_bit", bit_out, 1);
        check("dpsk2_cnt", sym_cnt, 1);
        for (int i = 0; i < 16; i++) send(((i % 4) < 2) ? 7'd28 : 7'd100);
        check("dpsk3_valid", bit_valid, 1);
        check("dpsk3_bit", bit_out, 0);
        check("dpsk3_cnt", sym_cnt, 2);
        idle(2);
        check("dpsk_pulse_count", pulses - p0, 2);

        // sel change: abort ASK after 10 samples; FSK symbol has 3 crossings only if first sample is not one
        do_reset(2'b00);
        p0 = pulses;
        for (int i = 0; i < 10; i++) send(7'd10);
        @(negedge clk);
        sel = 2'b01;
        idle(2);
        check("selchg_no_pulse", pulses - p0, 0);
        check("selchg_cnt_held", sym_cnt, 0);
        for (int i = 0; i < 15; i++) send((((i / 4) % 2) == 0) ? 7'd100 : 7'd28);
        check("selchg_full_symbol", bit_valid, 0);
        send(7'd28);
        check("selchg_fsk_valid", bit_valid, 1);
        check("selchg_fsk_bit", bit_out, 0);
        check("selchg_fsk_cnt", sym_cnt, 1);
        idle(2);
        check("selchg_pulse_count", pulses - p0, 1);

        // Asynchronous reset mid-symbol
        do_reset(2'b00);
        for (int i = 0; i < 16; i++) send(7'd127);
        check("prereset_bit", bit_out, 1);
        check("prereset_cnt", sym_cnt, 1);
        for (int i = 0; i < 5; i++) send(7'd127);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_bit", bit_out, 0);
        check("async_reset_valid", bit_valid, 0);
        check("async_reset_cnt", sym_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // sel=11: 40 valid samples ignored, outputs held
        for (int i = 0; i < 16; i++) send(7'd127);
        check("predis_bit", bit_out, 1);
        @(negedge clk);
        sel = 2'b11;
        idle(2);
        p0 = pulses;
        for (int i = 0; i < 40; i++) send(7'd127);
        idle(2);
        check("dis_no_pulse", pulses - p0, 0);
        check("dis_bit_held", bit_out, 1);
        check("dis_cnt_held", sym_cnt, 1);

        // Gapped ASK stream: one valid in three cycles
        do_reset(2'b00);
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            send(7'd127);
            if (i < 15) begin
                check("gap_no_early_valid", bit_valid, 0);
                idle(2);
            end
        end
        check("gap_valid", bit_valid, 1);
        check("gap_bit", bit_out, 1);
        check("gap_cnt", sym_cnt, 1);
        idle(3);
        check("gap_pulse_count", pulses - p0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
